// File: rtl/pmp_pkg.sv
// Shared types and helpers for the PMP assemble-phase blocks.
package pmp_pkg;

    localparam int MAX_KEEP_W     = 256;
    localparam int PMP_DATA_WIDTH = 16;
    localparam int PMP_BEAT_SIZE  = 8;

    function automatic int keep_width(input int data_width, input int beat_size);
        return (data_width * beat_size) / 8;
    endfunction

    // Byte enables for lanes 0..last_lane; callers cast down to their own keep width.
    function automatic logic [MAX_KEEP_W-1:0] lane_keep_mask(input int last_lane,
                                                             input int bytes_per_lane);
        logic [MAX_KEEP_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_KEEP_W; i++) begin
            if (i < (last_lane + 1) * bytes_per_lane) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

    localparam int PMP_KEEP_W = keep_width(PMP_DATA_WIDTH, PMP_BEAT_SIZE);

    // FIFO entry layout at the default widths; parameterised users mirror this field order.
    typedef struct packed {
        logic                                    tlast;
        logic [PMP_KEEP_W-1:0]                   tkeep;
        logic [PMP_DATA_WIDTH*PMP_BEAT_SIZE-1:0] tdata;
    } pmp_fifo_entry_t;

endpackage

// File: rtl/pmp_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push while full is accepted
// when a pop happens on the same edge.
module pmp_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_rd;
    logic             do_wr;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/assemble_packer.sv
// Packs selector samples into wide AXI4-Stream words, buffering them in a FIFO
// and accounting for words lost when the FIFO overflows.
module assemble_packer
    import pmp_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int BEAT_SIZE      = 8,
    parameter int FIFO_DEPTH     = 16,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DATA_WIDTH-1:0]           data_i,
    input  logic                            tlast_i,
    input  logic                            vld_i,
    output logic [BEAT_SIZE*DATA_WIDTH-1:0] m_axis_tdata,
    output logic [BEAT_SIZE*DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                            m_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            overflow_o,
    output logic [DROP_CNT_WIDTH-1:0]       drop_cnt_o
);

    localparam int TDATA_W    = DATA_WIDTH * BEAT_SIZE;
    localparam int KEEP_W     = keep_width(DATA_WIDTH, BEAT_SIZE);
    localparam int LANE_BYTES = DATA_WIDTH / 8;
    localparam int LANE_W     = $clog2(BEAT_SIZE);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BEAT_SIZE - 1);

    typedef struct packed {
        logic                tlast;
        logic [KEEP_W-1:0]   tkeep;
        logic [TDATA_W-1:0]  tdata;
    } entry_t;

    logic [LANE_W-1:0]  lane_cnt;
    logic [TDATA_W-1:0] acc;
    logic [TDATA_W-1:0] merged;
    logic               close_word;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               drop;
    entry_t             wr_entry;
    entry_t             rd_entry;

    // The closing sample is merged in combinationally so the word is pushed on its own edge.
    always_comb begin
        merged = acc;
        merged[int'(lane_cnt)*DATA_WIDTH +: DATA_WIDTH] = data_i;
    end

    assign close_word = vld_i & (tlast_i | (lane_cnt == LAST_LANE));

    always_comb begin
        wr_entry       = '0;
        wr_entry.tlast = tlast_i;
        wr_entry.tkeep = KEEP_W'(lane_keep_mask(int'(lane_cnt), LANE_BYTES));
        wr_entry.tdata = merged;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_cnt <= '0;
            acc      <= '0;
        end else if (vld_i) begin
            if (close_word) begin
                lane_cnt <= '0;
                acc      <= '0;
            end else begin
                lane_cnt <= lane_cnt + LANE_W'(1);
                acc      <= merged;
            end
        end
    end

    pmp_sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (close_word),
        .wr_data (wr_entry),
        .full    (fifo_full),
        .rd_en   (m_axis_tready),
        .rd_data (rd_entry),
        .empty   (fifo_empty)
    );

    assign m_axis_tvalid = ~fifo_empty;
    assign m_axis_tdata  = rd_entry.tdata;
    assign m_axis_tkeep  = rd_entry.tkeep;
    assign m_axis_tlast  = rd_entry.tlast;

    assign pop  = m_axis_tvalid & m_axis_tready;
    assign drop = close_word & fifo_full & ~pop;

    // Drop accounting is sticky until reset; the counter saturates rather than wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (drop) begin
            overflow_o <= 1'b1;
            if (drop_cnt_o != '1) begin
                drop_cnt_o <= drop_cnt_o + DROP_CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_assemble_packer.sv
// Randomised and directed bench for assemble_packer with a queue-based reference
// model feeding a scoreboard that a separate monitor drains.
module tb_assemble_packer;

    localparam int DW    = 16;
    localparam int BS    = 4;
    localparam int FD    = 4;
    localparam int DCW   = 16;

    logic            clk;
    logic            rst_n;
    logic [DW-1:0]   data_i;
    logic            tlast_i;
    logic            vld_i;
    logic [BS*DW-1:0]   m_axis_tdata;
    logic [BS*DW/8-1:0] m_axis_tkeep;
    logic            m_axis_tlast;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic            overflow_o;
    logic [DCW-1:0]  drop_cnt_o;

    typedef struct {
        logic [63:0] tdata;
        logic [7:0]  tkeep;
        logic        tlast;
    } word_t;

    word_t         exp_q[$];
    logic [DW-1:0] cur[$];
    int            occ = 0;
    int            drops = 0;
    int            checks = 0;
    int            errors = 0;
    bit            mon_en = 0;

    assemble_packer #(
        .DATA_WIDTH     (DW),
        .BEAT_SIZE      (BS),
        .FIFO_DEPTH     (FD),
        .DROP_CNT_WIDTH (DCW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_i        (data_i),
        .tlast_i       (tlast_i),
        .vld_i         (vld_i),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .overflow_o    (overflow_o),
        .drop_cnt_o    (drop_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [DW-1:0] d, input bit last, input bit v,
                                 input bit rdy);
        data_i        = d;
        tlast_i       = last;
        vld_i         = v;
        m_axis_tready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus('0, 0, 0, 1);
        applyStimulus('0, 0, 0, 1);
        rst_n = 1'b1;
    endtask

    task automatic sendWords(input int n, input bit rdy);
        for (int w = 0; w < n; w++) begin
            for (int s = 0; s < BS; s++) begin
                applyStimulus(DW'($urandom), (s == BS - 1), 1, rdy);
            end
        end
    endtask

    task automatic waitDrain(input int limit);
        int i;
        i = 0;
        while ((m_axis_tvalid || occ != 0) && i < limit) begin
            applyStimulus('0, 0, 0, 1);
            i++;
        end
        if (m_axis_tvalid || occ != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: tvalid=%0b, expected words left=%0d", m_axis_tvalid, occ);
        end
    endtask

    // Reference model: collects samples of the open word, builds the word with plain
    // arithmetic on close, and tracks FIFO occupancy to predict drops.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                cur.delete();
                exp_q.delete();
                occ   = 0;
                drops = 0;
            end else begin
                bit    pop_now;
                word_t w;
                pop_now = (occ > 0) && m_axis_tready;
                if (vld_i) begin
                    cur.push_back(data_i);
                    if (tlast_i || cur.size() == BS) begin
                        w.tdata = '0;
                        for (int i = 0; i < cur.size(); i++) begin
                            w.tdata = w.tdata | (64'(cur[i]) << (DW * i));
                        end
                        w.tkeep = 8'((1 << ((DW / 8) * cur.size())) - 1);
                        w.tlast = tlast_i;
                        cur.delete();
                        if (occ < FD || pop_now) begin
                            exp_q.push_back(w);
                            occ++;
                        end else begin
                            drops++;
                        end
                    end
                end
                if (pop_now) occ--;
            end
        end
    end

    // Monitor: compares whatever the DUT presents against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                checkOutput("tvalid", 64'(m_axis_tvalid), 64'(occ != 0));
                if (m_axis_tvalid && exp_q.size() > 0) begin
                    checkOutput("tdata", m_axis_tdata, exp_q[0].tdata);
                    checkOutput("tkeep", 64'(m_axis_tkeep), 64'(exp_q[0].tkeep));
                    checkOutput("tlast", 64'(m_axis_tlast), 64'(exp_q[0].tlast));
                    if (m_axis_tready && rst_n) void'(exp_q.pop_front());
                end else if (m_axis_tvalid) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_word: got tdata 0x%0h, expected no word", m_axis_tdata);
                end
                checkOutput("overflow", 64'(overflow_o), 64'(drops != 0));
                checkOutput("drop_cnt", 64'(drop_cnt_o), 64'((drops > 65535) ? 65535 : drops));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        data_i = '0;
        tlast_i = 1'b0;
        vld_i = 1'b0;
        m_axis_tready = 1'b1;
        doReset();
        mon_en = 1'b1;
        checkOutput("reset_tvalid", 64'(m_axis_tvalid), 64'(0));
        checkOutput("reset_drop_cnt", 64'(drop_cnt_o), 64'(0));

        applyStimulus(16'h1111, 0, 1, 1);
        applyStimulus(16'h2222, 0, 1, 1);
        applyStimulus(16'h3333, 0, 1, 1);
        checkOutput("tvalid_before_close", 64'(m_axis_tvalid), 64'(0));
        applyStimulus(16'h4444, 1, 1, 1);
        checkOutput("full_word_tvalid", 64'(m_axis_tvalid), 64'(1));
        checkOutput("full_word_tdata", m_axis_tdata, 64'h4444_3333_2222_1111);
        checkOutput("full_word_tkeep", 64'(m_axis_tkeep), 64'hFF);
        checkOutput("full_word_tlast", 64'(m_axis_tlast), 64'(1));
        applyStimulus('0, 0, 0, 1);

        applyStimulus(16'hAAAA, 0, 1, 1);
        applyStimulus(16'hBBBB, 1, 1, 1);
        checkOutput("short_tdata", m_axis_tdata, 64'h0000_0000_BBBB_AAAA);
        checkOutput("short_tkeep", 64'(m_axis_tkeep), 64'h0F);
        checkOutput("short_tlast", 64'(m_axis_tlast), 64'(1));
        applyStimulus(16'h5555, 1, 1, 1);
        checkOutput("lane0_after_short", m_axis_tdata, 64'h5555);
        applyStimulus('0, 0, 0, 1);

        begin
            logic [DW-1:0] gap_data [4];
            gap_data = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
            for (int s = 0; s < 4; s++) begin
                applyStimulus(gap_data[s], (s == 3), 1, 1);
                if (s != 3) begin
                    for (int g = 0; g < 3; g++) applyStimulus('0, 0, 0, 1);
                end
            end
        end
        checkOutput("gapped_tdata", m_axis_tdata, 64'h4444_3333_2222_1111);
        applyStimulus('0, 0, 0, 1);
        applyStimulus('0, 0, 0, 1);
        checkOutput("gapped_no_extra", 64'(m_axis_tvalid), 64'(0));

        doReset();
        sendWords(6, 0);
        checkOutput("ovf_flag", 64'(overflow_o), 64'(1));
        checkOutput("ovf_drop_cnt", 64'(drop_cnt_o), 64'(2));
        for (int i = 0; i < 3; i++) applyStimulus('0, 0, 0, 0);
        waitDrain(50);
        checkOutput("ovf_drop_cnt_hold", 64'(drop_cnt_o), 64'(2));

        doReset();
        sendWords(4, 0);
        for (int s = 0; s < BS - 1; s++) applyStimulus(DW'($urandom), 0, 1, 0);
        applyStimulus(DW'($urandom), 1, 1, 1);
        checkOutput("fullpop_drop_cnt", 64'(drop_cnt_o), 64'(0));
        checkOutput("fullpop_overflow", 64'(overflow_o), 64'(0));
        applyStimulus('0, 0, 0, 0);
        waitDrain(50);

        applyStimulus(16'h0A0A, 0, 1, 1);
        applyStimulus(16'h0B0B, 0, 1, 1);
        rst_n = 1'b0;
        applyStimulus('0, 0, 0, 1);
        rst_n = 1'b1;
        checkOutput("midrst_tvalid", 64'(m_axis_tvalid), 64'(0));
        checkOutput("midrst_overflow", 64'(overflow_o), 64'(0));
        checkOutput("midrst_drop_cnt", 64'(drop_cnt_o), 64'(0));
        applyStimulus(16'h0101, 0, 1, 1);
        applyStimulus(16'h0202, 0, 1, 1);
        applyStimulus(16'h0303, 0, 1, 1);
        applyStimulus(16'h0404, 0, 1, 1);
        checkOutput("midrst_word", m_axis_tdata, 64'h0404_0303_0202_0101);
        checkOutput("midrst_tlast", 64'(m_axis_tlast), 64'(0));
        applyStimulus('0, 0, 0, 1);

        doReset();
        for (int c = 0; c < 400; c++) begin
            applyStimulus(DW'($urandom), ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 7));
        end
        waitDrain(100);
        checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
